// File: rtl/uart_pkg.sv
// Shared definitions for the UART instruction receiver: byte FSM states and
// framing constants.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int BYTES_PER_WORD       = 4;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes rx, recovers bytes and flags framing errors.
// The current FSM state is exported so the word assembler can gate its timeout.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk12,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       stop_err,
    output logic       start_det,
    output rx_state_t  state
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_s;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;

    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // armed stays low after reset or a bad stop bit until the line is seen idle.
    assign start_det = (state == IDLE) && armed && !rx_s;

    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            stop_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!armed) begin
                        if (rx_s) armed <= 1'b1;
                    end else if (!rx_s) begin
                        state <= START;
                        cnt   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        byte_data <= {rx_s, byte_data[7:1]};
                        cnt       <= FULL_LOAD;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            stop_err  <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_inst_receiver.sv
// Packs four little-endian UART bytes into a 32-bit instruction word and hands
// it downstream over valid/ready; discards stale partial words after a timeout.
module uart_inst_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk12,
    input  logic        rst_n,
    input  logic        rx,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        frame_err,
    output logic        overrun
);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYCLES - 1);
    localparam logic [1:0]      IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        stop_err;
    logic        start_det;
    rx_state_t   rx_state;
    logic [1:0]  index;
    logic [23:0] partial;
    logic [TO_W-1:0] tcnt;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
        .clk12      (clk12),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .stop_err   (stop_err),
        .start_det  (start_det),
        .state      (rx_state)
    );

    // Handshake: a word transfers on any rising edge where inst_valid and
    // inst_ready are both high; inst_out is held stable while inst_valid is high.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            inst_out   <= '0;
            inst_valid <= 1'b0;
            overrun    <= 1'b0;
            index      <= '0;
            partial    <= '0;
            tcnt       <= '0;
        end else begin
            overrun <= 1'b0;
            if (inst_valid && inst_ready) inst_valid <= 1'b0;

            // A start bit restarts the idle count, so it beats a same-cycle timeout.
            if (start_det || rx_state != IDLE || index == '0) begin
                tcnt <= '0;
            end else if (tcnt == TO_LAST) begin
                tcnt  <= '0;
                index <= '0;
            end else begin
                tcnt <= tcnt + TO_W'(1);
            end

            if (stop_err) begin
                index <= '0;
            end else if (byte_valid) begin
                if (index == IDX_LAST) begin
                    index <= '0;
                    if (inst_valid && !inst_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        inst_out   <= {byte_data, partial};
                        inst_valid <= 1'b1;
                    end
                end else begin
                    index <= index + 2'd1;
                    case (index)
                        2'd0:    partial[7:0]   <= byte_data;
                        2'd1:    partial[15:8]  <= byte_data;
                        default: partial[23:16] <= byte_data;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_inst_receiver.sv
// Bench for uart_inst_receiver: serial driver tasks, a byte-queue reference
// model feeding an expected-word queue, and a monitor that checks handshakes.
module tb_uart_inst_receiver;
    localparam int CPB     = 8;
    localparam int TO_BITS = 20;

    logic        clk12 = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        frame_err;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    int exp_fe   = 0;
    int exp_ov   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  mq[$];
    logic [31:0] last_word = '0;
    logic [31:0] exp_word;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_out  = '0;
    logic        rr_en     = 1'b0;

    uart_inst_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk12      (clk12),
        .rst_n      (rst_n),
        .rx         (rx),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk12 = ~clk12;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: a queue of accepted bytes; four of them make a word.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok, input bit drop);
        logic [31:0] w;
        if (!stop_ok) begin
            mq.delete();
            exp_fe++;
            return;
        end
        mq.push_back(b);
        if (mq.size() == 4) begin
            w = 32'(mq[0]) + (32'(mq[1]) << 8) + (32'(mq[2]) << 16) + (32'(mq[3]) << 24);
            mq.delete();
            if (drop) exp_ov++;
            else begin
                exp_q.push_back(w);
                last_word = w;
            end
        end
    endtask

    // All drivers start and end on a falling clock edge.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int nbits);
        rx = 1'b0;
        repeat (CPB) @(negedge clk12);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk12);
        end
        if (nbits == 8) begin
            rx = stop_bit;
            repeat (CPB) @(negedge clk12);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk12);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 8);
        model_byte(b, 1'b1, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit drop);
        for (int i = 0; i < 4; i++) begin
            send_frame(w[8*i +: 8], 1'b1, 8);
            model_byte(w[8*i +: 8], 1'b1, (i == 3) ? drop : 1'b0);
        end
    endtask

    // Raises inst_ready for exactly the cycle in which byte 3 completes.
    task automatic send_word_pulse(input logic [31:0] w);
        for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
        fork
            send_frame(w[31:24], 1'b1, 8);
            begin
                repeat (79) @(negedge clk12);
                inst_ready = 1'b1;
                @(negedge clk12);
                inst_ready = 1'b0;
            end
        join
        model_byte(w[31:24], 1'b1, 1'b0);
    endtask

    task automatic pulse_ready();
        inst_ready = 1'b1;
        @(negedge clk12);
        inst_ready = 1'b0;
        @(negedge clk12);
    endtask

    always @(negedge clk12) begin
        #1;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (prev_hold) check("inst_out_stable", inst_out, prev_out);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", inst_out);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", inst_out, exp_word);
                end
            end
            prev_hold = inst_valid && !inst_ready;
            prev_out  = inst_out;
        end
    end

    initial begin
        forever begin
            @(negedge clk12);
            if (rr_en) inst_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        rx = 1'b1;
        inst_ready = 1'b0;
        repeat (3) @(negedge clk12);
        check("reset_inst_out", inst_out, 32'h0);
        check("reset_inst_valid", 32'(inst_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        // Single word held until a one-cycle ready.
        send_word(32'h00500093, 1'b0);
        idle_bits(1);
        check("single_valid", 32'(inst_valid), 32'h1);
        check("single_word", inst_out, last_word);
        pulse_ready();
        check("single_cleared", 32'(inst_valid), 32'h0);

        // Bad stop bit discards the partial word.
        inst_ready = 1'b1;
        send_byte(8'h5A);
        send_frame(8'h13, 1'b0, 8);
        model_byte(8'h13, 1'b0, 1'b0);
        idle_bits(2);
        send_word(32'hDEADBEEF, 1'b0);
        idle_bits(1);
        check("framing_word", inst_out, 32'hDEADBEEF);
        check("framing_fe_count", 32'(fe_seen), 32'(exp_fe));

        // Short glitch is a false start and keeps the byte index.
        send_byte(8'h11);
        rx = 1'b0;
        repeat (2) @(negedge clk12);
        exp_fe++;
        idle_bits(2);
        send_byte(8'h77);
        send_byte(8'h66);
        send_byte(8'h55);
        idle_bits(1);
        check("glitch_word", inst_out, 32'h55667711);
        check("glitch_fe_count", 32'(fe_seen), 32'(exp_fe));

        // Overrun: second word dropped while the first is unconsumed.
        inst_ready = 1'b0;
        @(negedge clk12);
        send_word(32'hA1B2C3D4, 1'b0);
        send_word(32'h0BADF00D, 1'b1);
        idle_bits(1);
        check("overrun_keep_valid", 32'(inst_valid), 32'h1);
        check("overrun_keep_word", inst_out, 32'hA1B2C3D4);
        check("overrun_count", 32'(ov_seen), 32'(exp_ov));
        pulse_ready();
        check("overrun_cleared", 32'(inst_valid), 32'h0);

        // Ready in the completion cycle loads the new word, no overrun.
        send_word(32'h12345678, 1'b0);
        send_word_pulse(32'hCAFEF00D);
        idle_bits(1);
        check("ready_same_cycle_valid", 32'(inst_valid), 32'h1);
        check("ready_same_cycle_word", inst_out, 32'hCAFEF00D);
        check("ready_same_cycle_no_ov", 32'(ov_seen), 32'(exp_ov));
        pulse_ready();

        // Timeout discards a stale partial word; a shorter gap does not.
        inst_ready = 1'b1;
        send_frame(8'hA1, 1'b1, 8);
        send_frame(8'hA2, 1'b1, 8);
        idle_bits(TO_BITS + 1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        idle_bits(1);
        check("timeout_word", inst_out, 32'h44332211);
        send_byte(8'hB1);
        idle_bits(TO_BITS - 5);
        send_byte(8'hB2);
        send_byte(8'hB3);
        send_byte(8'hB4);
        idle_bits(1);
        check("no_timeout_word", inst_out, 32'hB4B3B2B1);
        check("timeout_fe_count", 32'(fe_seen), 32'(exp_fe));

        // Reset in the middle of a data bit.
        send_byte(8'hC3);
        send_frame(8'h5A, 1'b1, 4);
        repeat (3) @(negedge clk12);
        rst_n = 1'b0;
        rx = 1'b1;
        mq.delete();
        #1;
        check("midreset_inst_out", inst_out, 32'h0);
        check("midreset_inst_valid", 32'(inst_valid), 32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_overrun", 32'(overrun), 32'h0);
        repeat (5) @(negedge clk12);
        rst_n = 1'b1;
        idle_bits(2);
        w = $urandom;
        send_word(w, 1'b0);
        idle_bits(1);
        check("post_reset_word", inst_out, w);

        // Random words, random gaps, random ready.
        rr_en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            w = $urandom;
            for (int i = 0; i < 4; i++) begin
                send_byte(w[8*i +: 8]);
                idle_bits($urandom_range(0, 2));
            end
        end
        rr_en = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk12);
        repeat (2) @(negedge clk12);
        check("drain_empty", 32'(exp_q.size()), 32'h0);
        check("final_fe_count", 32'(fe_seen), 32'(exp_fe));
        check("final_ov_count", 32'(ov_seen), 32'(exp_ov));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
